// File: rtl/dffsrq_shift_bank.sv
// dffsrq_shift_bank: shift register bank with set, parallel load, shift count and done flag
module dffsrq_shift_bank #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic             CK,
  input  logic             RSTN,
  input  logic             SET,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] PD,
  input  logic             EN,
  input  logic             D,
  output logic [WIDTH-1:0] Q,
  output logic             SO,
  output logic [CW-1:0]    CNT,
  output logic             DONE
);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);
  logic [WIDTH-1:0] q_q, q_d, shifted;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
  logic             done_q, done_d;
  if (WIDTH == 1) begin : g_one
    assign shifted = D;
  end else begin : g_wide
    assign shifted = {q_q[WIDTH-2:0], D};
  end
  assign cnt_inc = (cnt_q == FULL) ? cnt_q : cnt_q + 1'b1;
  // next state: SET beats LOAD beats shift beats hold
  always_comb begin
    q_d    = SET ? '1 : LOAD ? PD : EN ? shifted : q_q;
    cnt_d  = SET ? '0 : LOAD ? FULL : EN ? cnt_inc : cnt_q;
    done_d = SET ? 1'b0 : LOAD ? 1'b1 : EN ? (done_q | (cnt_inc == FULL)) : done_q;
  end
  // state registers, reset aborts any partial fill immediately
  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      q_q    <= RESET_VALUE;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end
  assign Q    = q_q;
  assign SO   = q_q[WIDTH-1];
  assign CNT  = cnt_q;
  assign DONE = done_q;
endmodule
